fifo_drain_sched: RTL and testbench

FIFO_DRAIN_SCHED -- requirements
Module: fifo_drain_sched

---
 rtl/fifo_drain_sched.sv | 133 +++++++++++++
 tb/tb_fifo_drain_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_sched.sv
// Burst-drain scheduler for a bank of FIFOs feeding one shared output mux.
// Urgent queues (almost full) win in IDLE; a round-robin pointer breaks ties.
module fifo_drain_sched #(
  parameter int unsigned NUM_Q     = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDX_W     = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [NUM_Q-1:0] empty_i,
  input  logic [NUM_Q-1:0] alm_full_i,
  output logic [NUM_Q-1:0] pop_o,
  output logic [IDX_W-1:0] sel_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W:0] NQ = (IDX_W + 1)'(NUM_Q);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_Q-1:0] w_urgent;
  logic [NUM_Q-1:0] w_cand;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_next;
  logic [IDX_W:0]   w_idx;
  logic             w_found;
  logic             w_xfer;
  logic             w_exit;

  // First candidate at or above ptr_q, wrapping modulo NUM_Q
  always_comb begin
    w_urgent = ~empty_i & alm_full_i;
    w_cand   = (|w_urgent) ? w_urgent : ~empty_i;
    w_pick   = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      w_idx = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (w_idx >= NQ) w_idx = w_idx - NQ;
      if (!w_found && w_cand[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_o = 1'b0;
    pop_o   = '0;
    busy_o  = 1'b0;
    sel_o   = grant_q;
    w_xfer  = 1'b0;
    w_exit  = 1'b0;
    w_next  = (grant_q == IDX_W'(NUM_Q - 1)) ? '0 : grant_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && w_found) begin
          grant_d = w_pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        busy_o         = 1'b1;
        valid_o        = ~empty_i[grant_q] & ~flush_i;
        w_xfer         = valid_o & ready_i;
        pop_o[grant_q] = w_xfer;
        if (w_xfer) cnt_d = cnt_q + 1'b1;
        w_exit = (w_xfer && cnt_q == CNT_W'(MAX_BURST - 1))
               || empty_i[grant_q] || flush_i;
        if (w_exit) begin
          state_d = IDLE;
          ptr_d   = w_next;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
  initial begin
    if (NUM_Q < 1 || NUM_Q > 32)
      $error("fifo_drain_sched: NUM_Q out of range");
    if (MAX_BURST < 1 || MAX_BURST > 255)
      $error("fifo_drain_sched: MAX_BURST out of range");
    if (IDX_W != ((NUM_Q > 1) ? $clog2(NUM_Q) : 1))
      $error("fifo_drain_sched: IDX_W must not be overridden");
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(pop_o))
        else $error("fifo_drain_sched: pop_o not onehot0");
      assert ((pop_o & empty_i) == '0)
        else $error("fifo_drain_sched: pop of empty queue");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Scoreboard bench for fifo_drain_sched: per-cycle expected
// pop/busy/valid/sel entries checked by an independent monitor.
module tb_fifo_drain_sched;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic [3:0] empty_i;
  logic [3:0] alm_full_i;
  logic [3:0] pop_o;
  logic [1:0] sel_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;

  int         lvl[4];
  logic [3:0] pend;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic [3:0] pop;
    logic       busy;
    logic       valid;
    logic [1:0] sel;
  } exp_t;

  exp_t sb[$];

  localparam int K_IDLE = 0;
  localparam int K_POP  = 1;
  localparam int K_DEAD = 2;
  localparam int K_STAL = 3;

  fifo_drain_sched #(
    .NUM_Q(4),
    .MAX_BURST(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .empty_i(empty_i),
    .alm_full_i(alm_full_i),
    .pop_o(pop_o),
    .sel_o(sel_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int q = 0; q < 4; q++) empty_i[q] = (lvl[q] == 0);
  end

  always @(negedge clk_i) pend = pop_o;

  // Monitor: one expected entry per cycle while the scoreboard holds any
  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (pop_o !== e.pop || busy_o !== e.busy || valid_o !== e.valid
          || (e.busy && sel_o !== e.sel)) begin
        n_fail++;
        $display("FAIL cycle t=%0t: pop=%b busy=%b valid=%b sel=%0d, expected pop=%b busy=%b valid=%b sel=%0d",
                 $time, pop_o, busy_o, valid_o, sel_o,
                 e.pop, e.busy, e.valid, e.sel);
      end
    end else if (!rst_i && pop_o !== 4'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL stray_pop t=%0t: pop=%b, expected 0000", $time, pop_o);
    end
  end

  task automatic ex(input int k, input int q, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.pop   = (k == K_POP) ? 4'(1 << q) : 4'b0;
      e.busy  = (k != K_IDLE);
      e.valid = (k == K_POP) || (k == K_STAL);
      e.sel   = 2'(q);
      sb.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Advance one cycle; apply last cycle's pops to the FIFO level model
  task automatic step();
    @(posedge clk_i);
    #1;
    for (int q = 0; q < 4; q++)
      if (pend[q] && lvl[q] > 0) lvl[q] = lvl[q] - 1;
    #1;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() > 0 && k < 300) begin
      step();
      k++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard not drained, %0d left, expected 0",
               name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input string name);
    rst_i      = 1'b1;
    flush_i    = 1'b0;
    ready_i    = 1'b0;
    alm_full_i = 4'b0;
    for (int q = 0; q < 4; q++) lvl[q] = 0;
    #1;
    chk({name, "_pop"}, pop_o, 4'b0);
    chk({name, "_valid"}, {3'b0, valid_o}, 4'b0);
    chk({name, "_busy"}, {3'b0, busy_o}, 4'b0);
    chk({name, "_sel"}, {2'b0, sel_o}, 4'b0);
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i      = 1'b1;
    flush_i    = 1'b0;
    ready_i    = 1'b0;
    alm_full_i = 4'b0;
    pend       = 4'b0;

    // Round robin, full bursts of 4 with one idle bubble between
    do_reset("rst_a");
    for (int q = 0; q < 4; q++) lvl[q] = 10;
    ready_i = 1'b1;
    ex(K_IDLE, 0, 1);
    for (int g = 0; g < 5; g++) begin
      ex(K_POP, g % 4, 4);
      ex(K_IDLE, 0, 1);
    end
    wait_drain("rr");

    // Short queue exits on empty; ptr then favours queue 3 over 0
    do_reset("rst_b");
    lvl[2]  = 2;
    ready_i = 1'b1;
    ex(K_IDLE, 0, 1);
    ex(K_POP, 2, 2);
    ex(K_DEAD, 2, 1);
    wait_drain("short");
    lvl[0] = 1;
    lvl[3] = 1;
    ex(K_IDLE, 0, 1);
    ex(K_POP, 3, 1);
    ex(K_DEAD, 3, 1);
    ex(K_IDLE, 0, 1);
    ex(K_POP, 0, 1);
    ex(K_DEAD, 0, 1);
    ex(K_IDLE, 0, 1);
    wait_drain("ptr3");

    // Urgent queue 3 first, then wrap to queue 0
    do_reset("rst_c");
    lvl[0]        = 8;
    lvl[3]        = 4;
    alm_full_i[3] = 1'b1;
    ready_i       = 1'b1;
    ex(K_IDLE, 0, 1);
    ex(K_POP, 3, 4);
    ex(K_IDLE, 0, 1);
    ex(K_POP, 0, 4);
    ex(K_IDLE, 0, 1);
    wait_drain("urgent");

    // Downstream stall mid-burst holds count
    do_reset("rst_d");
    lvl[1]  = 10;
    ready_i = 1'b1;
    ex(K_IDLE, 0, 1);
    ex(K_POP, 1, 2);
    ex(K_STAL, 1, 5);
    ex(K_POP, 1, 2);
    ex(K_IDLE, 0, 1);
    repeat (3) step();
    ready_i = 1'b0;
    repeat (5) step();
    ready_i = 1'b1;
    wait_drain("stall");

    // Flush on second pop cycle; ptr=2 so queue 3 beats queue 1
    do_reset("rst_e");
    lvl[1]  = 10;
    ready_i = 1'b1;
    ex(K_IDLE, 0, 1);
    ex(K_POP, 1, 1);
    ex(K_DEAD, 1, 1);
    ex(K_IDLE, 0, 1);
    ex(K_POP, 3, 1);
    ex(K_DEAD, 3, 1);
    ex(K_IDLE, 0, 1);
    step();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    lvl[3]  = 1;
    wait_drain("flush_burst");

    // Flush in IDLE blocks the grant for that cycle
    do_reset("rst_f");
    lvl[2]  = 3;
    ready_i = 1'b1;
    flush_i = 1'b1;
    ex(K_IDLE, 0, 2);
    ex(K_POP, 2, 3);
    ex(K_DEAD, 2, 1);
    ex(K_IDLE, 0, 1);
    step();
    flush_i = 1'b0;
    wait_drain("flush_idle");

    // Asynchronous reset mid-burst
    do_reset("rst_g");
    lvl[2]  = 10;
    ready_i = 1'b1;
    ex(K_IDLE, 0, 1);
    ex(K_POP, 2, 2);
    wait_drain("pre_rst");
    rst_i = 1'b1;
    #1;
    chk("midrst_pop", pop_o, 4'b0);
    chk("midrst_valid", {3'b0, valid_o}, 4'b0);
    chk("midrst_busy", {3'b0, busy_o}, 4'b0);
    step();
    step();
    lvl[0] = 1;
    rst_i  = 1'b0;
    ex(K_IDLE, 0, 1);
    ex(K_POP, 0, 1);
    ex(K_DEAD, 0, 1);
    ex(K_IDLE, 0, 1);
    wait_drain("post_rst");

    do_reset("rst_end");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
